// File: rtl/ibex_fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// ibex_fetch_req_ctrl
//
// Instruction-fetch request sequencer between the IF stage, the instruction
// memory bus and the fetch FIFO. It issues word-aligned fetch requests and
// tracks up to NUM_REQS outstanding responses in order. It throttles on FIFO
// occupancy. On a branch it clears the FIFO and marks in-flight responses
// stale, so the FIFO only ever sees valid, in-order, non-stale words.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i                fetching enabled
//   branch_i, addr_i     redirect fetch to addr_i this cycle
//   busy_o               request held or response outstanding
//   instr_req_o          bus request
//   instr_gnt_i          bus grant
//   instr_addr_o         bus word address ([1:0] = 0)
//   instr_rvalid_i       bus response valid
//   instr_rdata_i        bus response data
//   instr_err_i          bus response error
//   fifo_clear_o         FIFO clear (on branch)
//   fifo_busy_i          FIFO upper-entry occupancy
//   fifo_valid_o         push response word into FIFO
//   fifo_addr_o          FIFO start address (branch target)
//   fifo_rdata_o         response data to FIFO
//   fifo_err_o           response error to FIFO
// ---------------------------------------------------------------------------
module ibex_fetch_req_ctrl #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o
);

  localparam int CntW = $clog2(2 * NUM_REQS + 1);

  logic                r_validReq;
  logic                r_discardReq;
  logic [29:0]         r_storedAddr;
  logic [29:0]         r_fetchAddr;
  logic [NUM_REQS-1:0] r_rdataOutstanding;
  logic [NUM_REQS-1:0] r_branchDiscard;

  logic [CntW-1:0]     w_occupancy;
  logic                w_fifoReady;
  logic                w_validNewReq;
  logic                w_staleGnt;
  logic                w_granted;
  logic                w_slotFound;
  logic                w_discardReqNext;
  logic [29:0]         w_base;
  logic [29:0]         w_wordAddr;
  logic [NUM_REQS-1:0] w_rdataOutstandingNext;
  logic [NUM_REQS-1:0] w_branchDiscardNext;

  // Words already in the FIFO plus words still in flight must leave room for
  // one more response, otherwise a new request could overflow the FIFO.
  always_comb begin
    w_occupancy = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_occupancy = w_occupancy + CntW'(fifo_busy_i[i]) + CntW'(r_rdataOutstanding[i]);
    end
    w_fifoReady = (w_occupancy < CntW'(NUM_REQS));
  end

  // A branch may bypass the FIFO-space check because it clears the FIFO, but
  // it can never exceed the outstanding-response tracking capacity.
  assign w_validNewReq = req_i & (w_fifoReady | branch_i) & ~r_rdataOutstanding[NUM_REQS-1];
  assign instr_req_o   = r_validReq | w_validNewReq;
  assign w_base        = branch_i ? addr_i[31:2] : r_fetchAddr;
  assign w_wordAddr    = r_validReq ? r_storedAddr : w_base;
  assign instr_addr_o  = {w_wordAddr, 2'b00};

  // A held request cannot be withdrawn; if a branch arrives while it is held,
  // its grant (now or later) belongs to the old stream and is stale.
  assign w_staleGnt       = r_validReq & (r_discardReq | branch_i);
  assign w_granted        = instr_req_o & instr_gnt_i;
  assign w_discardReqNext = r_validReq & ~instr_gnt_i & (r_discardReq | branch_i);

  // Tracking vectors: retire the oldest on a response first (freeing the top
  // slot for a same-cycle grant), then mark survivors stale on a branch, then
  // allocate the lowest free slot for a grant.
  always_comb begin
    w_rdataOutstandingNext = r_rdataOutstanding;
    w_branchDiscardNext    = r_branchDiscard;
    w_slotFound            = 1'b0;
    if (instr_rvalid_i) begin
      w_rdataOutstandingNext = {1'b0, r_rdataOutstanding[NUM_REQS-1:1]};
      w_branchDiscardNext    = {1'b0, r_branchDiscard[NUM_REQS-1:1]};
    end
    if (branch_i) begin
      w_branchDiscardNext = w_branchDiscardNext | w_rdataOutstandingNext;
    end
    if (w_granted) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!w_slotFound && !w_rdataOutstandingNext[i]) begin
          w_rdataOutstandingNext[i] = 1'b1;
          w_branchDiscardNext[i]    = w_staleGnt;
          w_slotFound               = 1'b1;
        end
      end
    end
  end

  // The sequential address only advances on a grant that belongs to the
  // current stream; it wraps naturally in 30 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_validReq         <= 1'b0;
      r_discardReq       <= 1'b0;
      r_storedAddr       <= '0;
      r_fetchAddr        <= '0;
      r_rdataOutstanding <= '0;
      r_branchDiscard    <= '0;
    end else begin
      r_validReq         <= instr_req_o & ~instr_gnt_i;
      r_discardReq       <= w_discardReqNext;
      r_rdataOutstanding <= w_rdataOutstandingNext;
      r_branchDiscard    <= w_branchDiscardNext;
      r_fetchAddr        <= w_base + {29'd0, (w_granted & ~w_staleGnt)};
      if (instr_req_o && !instr_gnt_i && !r_validReq) begin
        r_storedAddr <= instr_addr_o[31:2];
      end
    end
  end

  // A response arriving with a branch belongs to the old stream.
  assign fifo_valid_o = instr_rvalid_i & ~r_branchDiscard[0] & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = r_validReq | (|r_rdataOutstanding);

  rvalidExpected: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> r_rdataOutstanding[0]);

  heldAddrStable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o && !instr_gnt_i) |=> (instr_addr_o == $past(instr_addr_o)));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibex_fetch_req_ctrl
//
// Directed bench for ibex_fetch_req_ctrl with a zero-wait / stalled bus
// driven by hand. Each step drives one cycle of inputs just after the rising
// edge and checks the combinational and registered outputs mid-cycle against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_ibex_fetch_req_ctrl;

  localparam int NUM_REQS = 2;

  logic                clk_i;
  logic                rst_ni;
  logic                req_i;
  logic                branch_i;
  logic [31:0]         addr_i;
  logic                busy_o;
  logic                instr_req_o;
  logic                instr_gnt_i;
  logic [31:0]         instr_addr_o;
  logic                instr_rvalid_i;
  logic [31:0]         instr_rdata_i;
  logic                instr_err_i;
  logic                fifo_clear_o;
  logic [NUM_REQS-1:0] fifo_busy_i;
  logic                fifo_valid_o;
  logic [31:0]         fifo_addr_o;
  logic [31:0]         fifo_rdata_o;
  logic                fifo_err_o;

  int vectors;
  int miscompares;

  ibex_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .busy_o         (busy_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits for the next rising edge, then drives one cycle of inputs.
  task automatic applyStimulus(input logic req, input logic branch, input logic [31:0] addr,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic err, input logic [NUM_REQS-1:0] fifoBusy);
    @(posedge clk_i);
    #1;
    req_i          = req;
    branch_i       = branch;
    addr_i         = addr;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rvalid;
    instr_rdata_i  = rdata;
    instr_err_i    = err;
    fifo_busy_i    = fifoBusy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_ni         = 1'b0;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    addr_i         = '0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    fifo_busy_i    = '0;

    // Reset state
    #2;
    checkOutput("rst_req",   {31'd0, instr_req_o},  32'd0);
    checkOutput("rst_busy",  {31'd0, busy_o},       32'd0);
    checkOutput("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
    checkOutput("rst_clear", {31'd0, fifo_clear_o}, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Sequential fetch, zero-wait bus
    applyStimulus(1, 1, 32'h100, 1, 0, 0, 0, 2'b00);
    checkOutput("seq_req0",   {31'd0, instr_req_o},  32'd1);
    checkOutput("seq_addr0",  instr_addr_o,          32'h100);
    checkOutput("seq_clear",  {31'd0, fifo_clear_o}, 32'd1);
    checkOutput("seq_faddr",  fifo_addr_o,           32'h100);
    applyStimulus(1, 0, 0, 1, 1, 32'hD000_0100, 0, 2'b00);
    checkOutput("seq_addr1",  instr_addr_o,          32'h104);
    checkOutput("seq_push0",  {31'd0, fifo_valid_o}, 32'd1);
    checkOutput("seq_data0",  fifo_rdata_o,          32'hD000_0100);
    checkOutput("seq_err0",   {31'd0, fifo_err_o},   32'd0);
    applyStimulus(1, 0, 0, 1, 1, 32'hD000_0104, 0, 2'b00);
    checkOutput("seq_addr2",  instr_addr_o,          32'h108);
    checkOutput("seq_push1",  {31'd0, fifo_valid_o}, 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'hD000_0108, 0, 2'b00);
    checkOutput("seq_noreq",  {31'd0, instr_req_o},  32'd0);
    checkOutput("seq_push2",  {31'd0, fifo_valid_o}, 32'd1);
    checkOutput("seq_busy",   {31'd0, busy_o},       32'd1);

    // Fill both outstanding slots, then the request must stop
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("full_idle",  {31'd0, busy_o},       32'd0);
    checkOutput("full_addr0", instr_addr_o,          32'h10C);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("full_addr1", instr_addr_o,          32'h110);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("full_block", {31'd0, instr_req_o},  32'd0);
    checkOutput("full_busy",  {31'd0, busy_o},       32'd1);
    applyStimulus(1, 0, 0, 1, 1, 32'hD000_010C, 0, 2'b00);
    checkOutput("full_blk2",  {31'd0, instr_req_o},  32'd0);
    checkOutput("full_push",  {31'd0, fifo_valid_o}, 32'd1);
    applyStimulus(1, 0, 0, 1, 1, 32'hD000_0110, 0, 2'b00);
    checkOutput("full_resume", instr_addr_o,         32'h114);
    checkOutput("full_rreq",  {31'd0, instr_req_o},  32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'hD000_0114, 0, 2'b00);
    checkOutput("full_drain", {31'd0, fifo_valid_o}, 32'd1);

    // FIFO backpressure
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b11);
    checkOutput("bp_block0",  {31'd0, instr_req_o},  32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b11);
    checkOutput("bp_block1",  {31'd0, instr_req_o},  32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("bp_resume",  {31'd0, instr_req_o},  32'd1);
    checkOutput("bp_addr",    instr_addr_o,          32'h118);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b01);
    checkOutput("bp_partial", {31'd0, instr_req_o},  32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'hD000_0118, 0, 2'b00);
    checkOutput("bp_push",    {31'd0, fifo_valid_o}, 32'd1);

    // Held request with a branch while held
    applyStimulus(1, 1, 32'h200, 0, 0, 0, 0, 2'b00);
    checkOutput("hold_addr0", instr_addr_o,          32'h200);
    applyStimulus(1, 1, 32'h402, 0, 0, 0, 0, 2'b00);
    checkOutput("hold_req1",  {31'd0, instr_req_o},  32'd1);
    checkOutput("hold_addr1", instr_addr_o,          32'h200);
    checkOutput("hold_clear", {31'd0, fifo_clear_o}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("hold_addr2", instr_addr_o,          32'h200);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("hold_gnt",   instr_addr_o,          32'h200);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("hold_target", instr_addr_o,         32'h400);
    checkOutput("hold_treq",  {31'd0, instr_req_o},  32'd1);
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0200, 0, 2'b00);
    checkOutput("hold_stale", {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 32'hD000_0400, 0, 2'b00);
    checkOutput("hold_push",  {31'd0, fifo_valid_o}, 32'd1);
    checkOutput("hold_data",  fifo_rdata_o,          32'hD000_0400);

    // Branch with two responses outstanding
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("br2_addr0",  instr_addr_o,          32'h404);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 2'b00);
    checkOutput("br2_addr1",  instr_addr_o,          32'h408);
    applyStimulus(1, 1, 32'h800, 0, 0, 0, 0, 2'b00);
    checkOutput("br2_full",   {31'd0, instr_req_o},  32'd0);
    applyStimulus(1, 0, 0, 0, 1, 32'hBAD0_0404, 0, 2'b00);
    checkOutput("br2_drop0",  {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(1, 0, 0, 1, 1, 32'hBAD0_0408, 0, 2'b00);
    checkOutput("br2_drop1",  {31'd0, fifo_valid_o}, 32'd0);
    checkOutput("br2_target", instr_addr_o,          32'h800);

    // Error propagation on the first new-target response
    applyStimulus(0, 0, 0, 0, 1, 32'hE000_0800, 1, 2'b00);
    checkOutput("err_push",   {31'd0, fifo_valid_o}, 32'd1);
    checkOutput("err_flag",   {31'd0, fifo_err_o},   32'd1);
    checkOutput("err_data",   fifo_rdata_o,          32'hE000_0800);

    // Address wrap, then branch coinciding with a response
    applyStimulus(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 2'b00);
    checkOutput("wrap_addr0", instr_addr_o,          32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 1, 1, 32'hD000_FFFC, 0, 2'b00);
    checkOutput("wrap_addr1", instr_addr_o,          32'h0000_0000);
    checkOutput("wrap_push",  {31'd0, fifo_valid_o}, 32'd1);
    applyStimulus(0, 1, 32'h300, 0, 1, 32'hBAD0_0000, 0, 2'b00);
    checkOutput("brrv_drop",  {31'd0, fifo_valid_o}, 32'd0);
    checkOutput("brrv_clear", {31'd0, fifo_clear_o}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("brrv_idle",  {31'd0, busy_o},       32'd0);

    // Reset in the middle of an outstanding response
    applyStimulus(1, 1, 32'h500, 1, 0, 0, 0, 2'b00);
    checkOutput("mrst_addr",  instr_addr_o,          32'h500);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("mrst_busy1", {31'd0, busy_o},       32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("mrst_busy0", {31'd0, busy_o},       32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("mrst_idle",  {31'd0, busy_o},       32'd0);
    checkOutput("mrst_req",   {31'd0, instr_req_o},  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
